// File: rtl/fp_pkg.sv
// Shared floating-point helpers: bias/limit functions, Regular-form field positions
// and the rounding-mode enumeration used by the converter and multiplier.
package fp_pkg;

    typedef enum logic {
        RND_TIES_AWAY,
        RND_NEAREST_EVEN
    } rnd_mode_e;

    localparam int FRAC_IDX_LO = 0;

    function automatic int bias(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

    function automatic int exp_max(input int exp_width);
        return (1 << exp_width) - 1;
    endfunction

    // Regular form is {sign, exponent, fraction}, fraction in the low bits
    function automatic int sign_idx(input int exp_width, input int frac_width);
        return exp_width + frac_width;
    endfunction

    function automatic int exp_idx_hi(input int exp_width, input int frac_width);
        return exp_width + frac_width - 1;
    endfunction

    function automatic int exp_idx_lo(input int frac_width);
        return frac_width;
    endfunction

    function automatic int frac_idx_hi(input int frac_width);
        return frac_width - 1;
    endfunction

endpackage

// File: rtl/floating_point_int_converter_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module leading_zero_counter #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scanning upward lets the highest set bit win the priority
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/floating_point_int_converter.sv
// Three-stage signed-integer to Regular-form floating-point converter with ready/valid stall.
// Define FP_INT_CONVERTER_RNE_EN for round-to-nearest-even; default rounds ties away from zero.
module floating_point_int_converter
    import fp_pkg::*;
#(
    parameter  int EXP_WIDTH    = 8,
    parameter  int FRAC_WIDTH   = 23,
    parameter  int INT_WIDTH    = 32,
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [INT_WIDTH-1:0]    int_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [FP_WIDTH_REG-1:0] fp_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    localparam int BIAS        = bias(EXP_WIDTH);
    localparam int EXP_MAX     = exp_max(EXP_WIDTH);
    localparam int LZ_W        = $clog2(INT_WIDTH + 1);
    // Wide enough for BIAS + 63 even with very narrow exponents
    localparam int E_W         = (EXP_WIDTH + 2 > 9) ? EXP_WIDTH + 2 : 9;
    localparam int EXT_W       = INT_WIDTH + FRAC_WIDTH + 1;
    localparam int SIGN_IDX    = sign_idx(EXP_WIDTH, FRAC_WIDTH);
    localparam int EXP_IDX_HI  = exp_idx_hi(EXP_WIDTH, FRAC_WIDTH);
    localparam int EXP_IDX_LO  = exp_idx_lo(FRAC_WIDTH);
    localparam int FRAC_IDX_HI = frac_idx_hi(FRAC_WIDTH);

`ifdef FP_INT_CONVERTER_RNE_EN
    localparam rnd_mode_e RND_MODE = RND_NEAREST_EVEN;
`else
    localparam rnd_mode_e RND_MODE = RND_TIES_AWAY;
`endif

    logic advance;

    logic                    s1_valid;
    logic                    s1_sign;
    logic                    s1_zero;
    logic [INT_WIDTH-1:0]    s1_mag;

    logic [LZ_W-1:0]         s1_lz;
    logic [INT_WIDTH-1:0]    s2_norm_d;
    logic signed [E_W-1:0]   s2_exp_d;

    logic                    s2_valid;
    logic                    s2_sign;
    logic                    s2_zero;
    logic [INT_WIDTH-1:0]    s2_norm;
    logic signed [E_W-1:0]   s2_exp;

    logic [EXT_W-1:0]        ext;
    logic [FRAC_WIDTH-1:0]   frac_t;
    logic [FRAC_WIDTH-1:0]   frac_r;
    logic                    guard;
    logic                    sticky;
    logic                    round_up;
    logic                    carry;
    logic signed [E_W-1:0]   exp_r;
    logic [FP_WIDTH_REG-1:0] fp_d;

    // One global enable: the whole pipe freezes only when a held result is refused
    assign advance = ready_i | ~valid_o;
    assign ready_o = advance;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_mag   <= '0;
        end else if (advance) begin
            s1_valid <= valid_i;
            s1_sign  <= int_i[INT_WIDTH-1];
            s1_zero  <= (int_i == '0);
            s1_mag   <= int_i[INT_WIDTH-1] ? -int_i : int_i;
        end
    end

    leading_zero_counter #(
        .WIDTH (INT_WIDTH)
    ) u_lzc (
        .value (s1_mag),
        .count (s1_lz)
    );

    assign s2_norm_d = s1_mag << s1_lz;
    assign s2_exp_d  = E_W'(BIAS + INT_WIDTH - 1) - $signed({{(E_W - LZ_W){1'b0}}, s1_lz});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_norm  <= '0;
            s2_exp   <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_zero  <= s1_zero;
            s2_norm  <= s2_norm_d;
            s2_exp   <= s2_exp_d;
        end
    end

    // Right-padding with zeros covers integers narrower than the fraction field
    assign ext      = {s2_norm[INT_WIDTH-2:0], {(FRAC_WIDTH + 2){1'b0}}};
    assign frac_t   = ext[EXT_W-1 -: FRAC_WIDTH];
    assign guard    = ext[EXT_W-1-FRAC_WIDTH];
    assign sticky   = |ext[EXT_W-2-FRAC_WIDTH:0];
    assign round_up = guard & ((RND_MODE == RND_TIES_AWAY) | sticky | frac_t[0]);
    assign {carry, frac_r} = {1'b0, frac_t} + {{FRAC_WIDTH{1'b0}}, round_up};
    assign exp_r    = s2_exp + $signed({{(E_W - 1){1'b0}}, carry});

    always_comb begin
        fp_d = '0;
        if (!s2_zero && s2_norm[INT_WIDTH-1]) begin
            fp_d[SIGN_IDX] = s2_sign;
            if (exp_r >= E_W'(EXP_MAX)) begin
                fp_d[EXP_IDX_HI:EXP_IDX_LO] = '1;
            end else begin
                fp_d[EXP_IDX_HI:EXP_IDX_LO]   = exp_r[EXP_WIDTH-1:0];
                fp_d[FRAC_IDX_HI:FRAC_IDX_LO] = frac_r;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            fp_o    <= '0;
        end else if (advance) begin
            valid_o <= s2_valid;
            fp_o    <= fp_d;
        end
    end

endmodule

// File: tb/tb_floating_point_int_converter.sv
// Directed, table-driven bench for floating_point_int_converter (single and half-precision builds).
module tb_floating_point_int_converter;

    logic        clk;
    logic        rst;

    logic [31:0] int_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] fp_o;
    logic        valid_o;
    logic        ready_i;

    logic [31:0] h_int;
    logic        h_valid_i;
    logic        h_ready_o;
    logic [15:0] h_fp;
    logic        h_valid_o;
    logic        h_ready_i;

    typedef struct {
        logic [31:0] val;
        logic [31:0] expFp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] val;
        logic [15:0] expFp;
        string       name;
    } hvec_t;

    vec_t  vecs[12];
    hvec_t hvecs[5];

    int assertCount = 0;
    int failCount   = 0;

    floating_point_int_converter dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .int_i   (int_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .fp_o    (fp_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    floating_point_int_converter #(
        .EXP_WIDTH  (5),
        .FRAC_WIDTH (10),
        .INT_WIDTH  (32)
    ) dut_half (
        .clk_i   (clk),
        .rst_i   (rst),
        .int_i   (h_int),
        .valid_i (h_valid_i),
        .ready_o (h_ready_o),
        .fp_o    (h_fp),
        .valid_o (h_valid_o),
        .ready_i (h_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic rdy);
        valid_i = v;
        int_i   = d;
        ready_i = rdy;
    endtask

    // Streams vecs[first +: n] while ready_i is low for cycles [stallStart, stallStart+stallLen)
    task automatic runStream(input int first, input int n, input int stallStart, input int stallLen,
                             input bit checkLat, input string tag);
        int          qIdx[$];
        int          qT[$];
        int          idx;
        int          done;
        int          k;
        int          ta;
        logic        rdy;
        logic [31:0] held;
        bit          holdPending;
        idx         = first;
        done        = 0;
        holdPending = 1'b0;
        held        = '0;
        for (int t = 0; t < 200 && done < n; t++) begin
            @(negedge clk);
            rdy = !(t >= stallStart && t < stallStart + stallLen);
            if (idx < first + n) applyStimulus(1'b1, vecs[idx].val, rdy);
            else                 applyStimulus(1'b0, '0, rdy);
            #1;
            if (holdPending) begin
                checkOutput({tag, " hold fp_o"}, fp_o, held);
                checkOutput({tag, " hold valid_o"}, 32'(valid_o), 32'd1);
                holdPending = 1'b0;
            end
            if (valid_o) begin
                if (rdy) begin
                    if (qIdx.size() == 0) begin
                        checkOutput({tag, " spurious valid_o"}, 32'(valid_o), 32'd0);
                    end else begin
                        k  = qIdx.pop_front();
                        ta = qT.pop_front();
                        checkOutput({tag, " ", vecs[k].name}, fp_o, vecs[k].expFp);
                        if (checkLat) checkOutput({tag, " latency ", vecs[k].name}, t, ta + 3);
                        done++;
                    end
                end else begin
                    held        = fp_o;
                    holdPending = 1'b1;
                    checkOutput({tag, " ready_o while stalled"}, 32'(ready_o), 32'd0);
                end
            end
            if (valid_i && ready_o) begin
                qIdx.push_back(idx);
                qT.push_back(t);
                idx++;
            end
        end
        checkOutput({tag, " results drained"}, done, n);
        applyStimulus(1'b0, '0, 1'b1);
    endtask

    task automatic runHalf(input int i);
        int lat;
        lat = 0;
        @(negedge clk);
        h_valid_i = 1'b1;
        h_int     = hvecs[i].val;
        h_ready_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            h_valid_i = 1'b0;
            #1;
            if (h_valid_o) begin
                lat = k;
                break;
            end
        end
        checkOutput({"half latency ", hvecs[i].name}, lat, 3);
        checkOutput({"half ", hvecs[i].name}, {16'h0, h_fp}, {16'h0, hvecs[i].expFp});
    endtask

    initial begin
        int lat;

        vecs[0]  = '{32'd1,        32'h3F800000, "one"};
        vecs[1]  = '{32'hFFFFFFFF, 32'hBF800000, "minus_one"};
        vecs[2]  = '{32'd0,        32'h00000000, "zero"};
        vecs[3]  = '{32'h80000000, 32'hCF000000, "int_min"};
        vecs[4]  = '{32'h7FFFFFFF, 32'h4F000000, "int_max_carry"};
`ifdef FP_INT_CONVERTER_RNE_EN
        vecs[5]  = '{32'd16777217, 32'h4B800000, "tie_2p24_plus1"};
`else
        vecs[5]  = '{32'd16777217, 32'h4B800001, "tie_2p24_plus1"};
`endif
        vecs[6]  = '{32'd16777219, 32'h4B800002, "tie_2p24_plus3"};
        vecs[7]  = '{32'd2,        32'h40000000, "two"};
        vecs[8]  = '{32'd3,        32'h40400000, "three"};
        vecs[9]  = '{32'hFFFFFFFB, 32'hC0A00000, "minus_five"};
        vecs[10] = '{32'd100,      32'h42C80000, "hundred"};
        vecs[11] = '{32'd33554435, 32'h4C000001, "above_half_2p25"};

        hvecs[0] = '{32'd65504,    16'h7BFF, "max_finite"};
        hvecs[1] = '{32'd65536,    16'h7C00, "pos_inf"};
        hvecs[2] = '{32'hFFFEEE90, 16'hFC00, "neg_inf"};
        hvecs[3] = '{32'd1,        16'h3C00, "one"};
        hvecs[4] = '{32'hFFFFFFFE, 16'hC000, "minus_two"};

        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b1);
        h_valid_i = 1'b0;
        h_int     = '0;
        h_ready_i = 1'b1;
        #1;
        checkOutput("reset valid_o", 32'(valid_o), 32'd0);
        checkOutput("reset fp_o", fp_o, 32'd0);
        checkOutput("reset ready_o", 32'(ready_o), 32'd1);
        checkOutput("reset half valid_o", 32'(h_valid_o), 32'd0);
        checkOutput("reset half fp_o", {16'h0, h_fp}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] back-to-back stream");
        runStream(0, 12, 1000, 0, 1'b1, "stream");

        $display("[TB] backpressure stream");
        runStream(0, 8, 5, 5, 1'b0, "bp");

        $display("[TB] reset with conversions in flight");
        @(negedge clk); applyStimulus(1'b1, 32'd5, 1'b1);
        @(negedge clk); applyStimulus(1'b1, 32'd6, 1'b1);
        @(negedge clk); applyStimulus(1'b1, 32'd7, 1'b1);
        @(posedge clk);
        #2;
        checkOutput("valid_o before reset", 32'(valid_o), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("valid_o async reset", 32'(valid_o), 32'd0);
        checkOutput("fp_o async reset", fp_o, 32'd0);
        applyStimulus(1'b0, '0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("ready_o after reset", 32'(ready_o), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checkOutput("no ghost valid_o", 32'(valid_o), 32'd0);
        end
        @(negedge clk);
        applyStimulus(1'b1, 32'd7, 1'b1);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, '0, 1'b1);
            #1;
            if (valid_o) begin
                lat = k;
                break;
            end
        end
        checkOutput("post-reset latency", lat, 3);
        checkOutput("post-reset seven", fp_o, 32'h40E00000);

        $display("[TB] half-precision build");
        for (int i = 0; i < 5; i++) runHalf(i);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
